// File: rtl/rom_dl_sequencer.sv
// ROM-download sequencer: buffers hps_io bytes in a small FIFO and issues them one at a time
// to the two SDRAM write ports using toggle req/ack handshakes.
module rom_dl_sequencer #(
    parameter logic [24:0] SPR_BASE    = 25'h10000,
    parameter logic [24:0] SPR_END     = 25'h1C000,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        port_we,
    output logic        cpu_hold,
    output logic        dl_done,
    output logic        ack_err
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [8:0] TimeoutLim = 9'(ACK_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StDecode, StIssue, StWait} state_e;

    state_e state_q, state_d;

    logic            wr_last_q, dl_last_q;
    logic            push, push_ok, pop;
    logic [32:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            fifo_full, fifo_empty;
    logic            wait_q, wait_d;

    logic [32:0]     cur_q, cur_d;
    logic [24:0]     cur_addr, spr_off;
    logic [7:0]      cur_dout;
    logic            sel_q, sel_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            timeout;
    logic            ack_eff, req_sel;

    logic            req1_q, req1_d, req2_q, req2_d;
    logic            ofs1_q, ofs1_d, ofs2_q, ofs2_d;
    logic            ack_err_q, ack_err_d;
    logic [22:0]     p1_a_q, p1_a_d, p2_a_q, p2_a_d;
    logic [1:0]      p1_ds_q, p1_ds_d, p2_ds_q, p2_ds_d;
    logic [15:0]     p1_d_q, p1_d_d, p2_d_q, p2_d_d;
    logic            we_q, we_d;
    logic            hold_q, hold_d;
    logic            done_q, done_d;
    logic            unused_bits;

    // Capture on the rising edge of the strobe only; hps_io may hold ioctl_wr for several cycles.
    assign push       = ioctl_wr & ~wr_last_q & ioctl_download & (ioctl_index == 8'd0);
    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push_ok    = push & ~fifo_full;

    assign cur_addr = cur_q[32:8];
    assign cur_dout = cur_q[7:0];
    assign spr_off  = cur_addr - SPR_BASE;
    assign unused_bits = ^{spr_off[24], cur_addr[24]};

    assign req_sel = sel_q ? req2_q : req1_q;
    // Offsets absorb acks lost to a timeout so the next handshake lines up again.
    assign ack_eff = sel_q ? (port2_ack ^ ofs2_q) : (port1_ack ^ ofs1_q);
    assign timeout = (({1'b0, cnt_q} + 9'd1) >= TimeoutLim);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    assign wait_d = (count_d >= CntW'(FIFO_DEPTH - 1));

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        cur_d     = cur_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        req1_d    = req1_q;
        req2_d    = req2_q;
        ofs1_d    = ofs1_q;
        ofs2_d    = ofs2_q;
        ack_err_d = ack_err_q;
        p1_a_d    = p1_a_q;
        p1_ds_d   = p1_ds_q;
        p1_d_d    = p1_d_q;
        p2_a_d    = p2_a_q;
        p2_ds_d   = p2_ds_q;
        p2_d_d    = p2_d_q;

        if (ioctl_download && !dl_last_q) begin
            ack_err_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cur_d   = mem_q[rd_ptr_q];
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (cur_addr < SPR_BASE) begin
                    p1_a_d  = cur_addr[23:1];
                    p1_ds_d = {cur_addr[0], ~cur_addr[0]};
                    p1_d_d  = {cur_dout, cur_dout};
                    sel_d   = 1'b0;
                    state_d = StIssue;
                end else if (cur_addr < SPR_END) begin
                    // Sprite ROM is stored as merged 32-bit words: s[14] picks the byte lane.
                    p2_a_d  = {spr_off[23:16], spr_off[13:0], spr_off[15]};
                    p2_ds_d = {spr_off[14], ~spr_off[14]};
                    p2_d_d  = {cur_dout, cur_dout};
                    sel_d   = 1'b1;
                    state_d = StIssue;
                end else begin
                    state_d = StIdle;
                end
            end
            StIssue: begin
                if (sel_q) begin
                    req2_d = ~req2_q;
                end else begin
                    req1_d = ~req1_q;
                end
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (ack_eff == req_sel) begin
                    state_d = StIdle;
                end else if (timeout) begin
                    ack_err_d = 1'b1;
                    if (sel_q) begin
                        ofs2_d = port2_ack ^ req2_q;
                    end else begin
                        ofs1_d = port1_ack ^ req1_q;
                    end
                    state_d = StIdle;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign we_d   = (state_d == StIssue) || (state_d == StWait);
    assign hold_d = ioctl_download | ~fifo_empty | (state_q != StIdle);
    assign done_d = hold_q & ~hold_d;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {ioctl_addr, ioctl_dout};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            wr_last_q <= 1'b0;
            dl_last_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wait_q    <= 1'b0;
            cur_q     <= '0;
            sel_q     <= 1'b0;
            cnt_q     <= '0;
            req1_q    <= 1'b0;
            req2_q    <= 1'b0;
            ofs1_q    <= 1'b0;
            ofs2_q    <= 1'b0;
            ack_err_q <= 1'b0;
            p1_a_q    <= '0;
            p1_ds_q   <= '0;
            p1_d_q    <= '0;
            p2_a_q    <= '0;
            p2_ds_q   <= '0;
            p2_d_q    <= '0;
            we_q      <= 1'b0;
            hold_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_last_q <= ioctl_wr;
            dl_last_q <= ioctl_download;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q   <= count_d;
            wait_q    <= wait_d;
            cur_q     <= cur_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            req1_q    <= req1_d;
            req2_q    <= req2_d;
            ofs1_q    <= ofs1_d;
            ofs2_q    <= ofs2_d;
            ack_err_q <= ack_err_d;
            p1_a_q    <= p1_a_d;
            p1_ds_q   <= p1_ds_d;
            p1_d_q    <= p1_d_d;
            p2_a_q    <= p2_a_d;
            p2_ds_q   <= p2_ds_d;
            p2_d_q    <= p2_d_d;
            we_q      <= we_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
        end
    end

    assign ioctl_wait = wait_q;
    assign port1_req  = req1_q;
    assign port1_a    = p1_a_q;
    assign port1_ds   = p1_ds_q;
    assign port1_d    = p1_d_q;
    assign port2_req  = req2_q;
    assign port2_a    = p2_a_q;
    assign port2_ds   = p2_ds_q;
    assign port2_d    = p2_d_q;
    assign port_we    = we_q;
    assign cpu_hold   = hold_q;
    assign dl_done    = done_q;
    assign ack_err    = ack_err_q;

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Directed bench for rom_dl_sequencer: an SDRAM ack model plus a log of every issued write.
module tb_rom_dl_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        dl, wr;
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic        ioctl_wait;
    logic        port1_req, port2_req, ack1, ack2;
    logic [22:0] port1_a, port2_a;
    logic [1:0]  port1_ds, port2_ds;
    logic [15:0] port1_d, port2_d;
    logic        port_we, cpu_hold, dl_done, ack_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [41:0] log_q[$];
    logic        ack_en, ack_drop;

    always #5 clk = ~clk;

    rom_dl_sequencer dut (
        .clk            (clk),
        .reset          (rst),
        .ioctl_download (dl),
        .ioctl_wr       (wr),
        .ioctl_index    (idx),
        .ioctl_addr     (addr),
        .ioctl_dout     (dout),
        .ioctl_wait     (ioctl_wait),
        .port1_req      (port1_req),
        .port1_ack      (ack1),
        .port1_a        (port1_a),
        .port1_ds       (port1_ds),
        .port1_d        (port1_d),
        .port2_req      (port2_req),
        .port2_ack      (ack2),
        .port2_a        (port2_a),
        .port2_ds       (port2_ds),
        .port2_d        (port2_d),
        .port_we        (port_we),
        .cpu_hold       (cpu_hold),
        .dl_done        (dl_done),
        .ack_err        (ack_err)
    );

    function automatic logic [41:0] mk(input logic port, input logic [22:0] a,
                                       input logic [1:0] ds, input logic [15:0] d);
        return {port, a, ds, d};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a;
        dout = d;
        wr   = 1'b1;
        @(negedge clk);
        wr   = 1'b0;
    endtask

    task automatic wait_log(input int n);
        for (int i = 0; i < 300 && log_q.size() < n; i++) @(negedge clk);
        check_val("log_count", 64'(log_q.size()), 64'(n));
    endtask

    // SDRAM model: one ack toggle per req toggle; requests seen while ack_drop is set are lost.
    initial begin
        int  pend1, pend2;
        logic seen1, seen2;
        pend1 = 0; pend2 = 0; seen1 = 0; seen2 = 0;
        ack1 = 1'b0; ack2 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend1 = 0; pend2 = 0; seen1 = 0; seen2 = 0;
                ack1 = 1'b0; ack2 = 1'b0;
            end else begin
                if (port1_req != seen1) begin
                    seen1 = port1_req;
                    if (!ack_drop) pend1++;
                end
                if (port2_req != seen2) begin
                    seen2 = port2_req;
                    if (!ack_drop) pend2++;
                end
                if (ack_en && pend1 > 0) begin ack1 = ~ack1; pend1--; end
                if (ack_en && pend2 > 0) begin ack2 = ~ack2; pend2--; end
            end
        end
    end

    // Write monitor: log address/strobe/data at each req toggle.
    initial begin
        logic l1, l2;
        l1 = 1'b0; l2 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                l1 = 1'b0; l2 = 1'b0;
            end else begin
                if (port1_req != l1) begin
                    l1 = port1_req;
                    log_q.push_back(mk(1'b0, port1_a, port1_ds, port1_d));
                end
                if (port2_req != l2) begin
                    l2 = port2_req;
                    log_q.push_back(mk(1'b1, port2_a, port2_ds, port2_d));
                end
            end
        end
    end

    initial begin
        int   base, cyc, dones;
        logic seen_we, prev_hold, prev_req;
        rst = 1'b1; dl = 1'b0; wr = 1'b0; idx = 8'd0; addr = '0; dout = '0;
        ack_en = 1'b1; ack_drop = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_req1", port1_req, 0);
        check_val("rst_req2", port2_req, 0);
        check_val("rst_we", port_we, 0);
        check_val("rst_wait", ioctl_wait, 0);
        check_val("rst_hold", cpu_hold, 0);
        check_val("rst_done", dl_done, 0);
        check_val("rst_err", ack_err, 0);
        check_val("rst_p1", {port1_a, port1_ds, port1_d}, 0);
        check_val("rst_p2", {port2_a, port2_ds, port2_d}, 0);
        rst = 1'b0;
        dl  = 1'b1;

        // Port1 low/high byte pair.
        send_byte(25'h0, 8'hAA);
        wait_log(1);
        check_val("p1_lo", log_q[0], mk(1'b0, 23'h0, 2'b01, 16'hAAAA));
        send_byte(25'h1, 8'h55);
        wait_log(2);
        check_val("p1_hi", log_q[1], mk(1'b0, 23'h0, 2'b10, 16'h5555));
        repeat (3) @(negedge clk);
        check_val("p1_req_twice", port1_req, 0);
        check_val("p2_req_idle", port2_req, 0);

        // Sprite region.
        send_byte(25'h14001, 8'h3C);
        wait_log(3);
        check_val("p2_map", log_q[2], mk(1'b1, 23'h2, 2'b10, 16'h3C3C));
        check_val("p1_held", port1_d, 16'h5555);

        // Out-of-range address and non-zero index produce no write.
        base = log_q.size();
        send_byte(25'h1C000, 8'h77);
        idx = 8'd1;
        send_byte(25'h2, 8'h11);
        idx = 8'd0;
        seen_we = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen_we |= port_we;
        end
        check_val("drop_no_write", 64'(log_q.size()), 64'(base));
        check_val("drop_no_we", seen_we, 0);
        check_val("drop_p2_held", port2_d, 16'h3C3C);

        // Back-pressure with acks withheld.
        ack_en = 1'b0;
        base = log_q.size();
        send_byte(25'h10, 8'h01);
        send_byte(25'h11, 8'h02);
        send_byte(25'h12, 8'h03);
        check_val("wait_two_buffered", ioctl_wait, 0);
        send_byte(25'h13, 8'h04);
        check_val("wait_three_buffered", ioctl_wait, 1);
        ack_en = 1'b1;
        wait_log(base + 4);
        check_val("bp_w0", log_q[base],     mk(1'b0, 23'h8, 2'b01, 16'h0101));
        check_val("bp_w1", log_q[base + 1], mk(1'b0, 23'h8, 2'b10, 16'h0202));
        check_val("bp_w2", log_q[base + 2], mk(1'b0, 23'h9, 2'b01, 16'h0303));
        check_val("bp_w3", log_q[base + 3], mk(1'b0, 23'h9, 2'b10, 16'h0404));
        repeat (3) @(negedge clk);
        check_val("wait_released", ioctl_wait, 0);

        // Ack timeout.
        check_val("err_before", ack_err, 0);
        ack_drop = 1'b1;
        prev_req = port1_req;
        send_byte(25'h20, 8'h99);
        for (int i = 0; i < 20 && port1_req == prev_req; i++) @(negedge clk);
        cyc = 0;
        while (!ack_err && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check_val("timeout_cycles", 64'(cyc), 64'd255);
        ack_drop = 1'b0;
        base = log_q.size();
        send_byte(25'h21, 8'h66);
        wait_log(base + 1);
        repeat (4) @(negedge clk);
        check_val("after_timeout_idle", port_we, 0);
        check_val("after_timeout_data", port1_d, 16'h6666);
        check_val("err_sticky", ack_err, 1);
        dl = 1'b0;
        repeat (3) @(negedge clk);
        dl = 1'b1;
        repeat (2) @(negedge clk);
        check_val("err_cleared", ack_err, 0);

        // Drain after download falls.
        ack_en = 1'b0;
        base = log_q.size();
        send_byte(25'h30, 8'hA1);
        send_byte(25'h31, 8'hB2);
        dl = 1'b0;
        repeat (3) @(negedge clk);
        check_val("drain_hold", cpu_hold, 1);
        ack_en = 1'b1;
        dones = 0;
        prev_hold = cpu_hold;
        repeat (40) begin
            @(negedge clk);
            if (dl_done) begin
                dones++;
                check_val("done_hold_falls", {prev_hold, cpu_hold}, 2'b10);
                check_val("done_after_writes", 64'(log_q.size()), 64'(base + 2));
            end
            prev_hold = cpu_hold;
        end
        check_val("done_once", 64'(dones), 64'd1);
        check_val("drain_w0", log_q[base],     mk(1'b0, 23'h18, 2'b01, 16'hA1A1));
        check_val("drain_w1", log_q[base + 1], mk(1'b0, 23'h18, 2'b10, 16'hB2B2));

        // Reset while waiting for an ack.
        dl = 1'b1;
        ack_en = 1'b0;
        prev_req = port1_req;
        send_byte(25'h40, 8'hC3);
        send_byte(25'h41, 8'hD4);
        for (int i = 0; i < 20 && port1_req == prev_req; i++) @(negedge clk);
        check_val("pre_rst_req", port1_req, 1);
        check_val("pre_rst_we", port_we, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_req", port1_req, 0);
        check_val("async_rst_we", port_we, 0);
        check_val("async_rst_hold", cpu_hold, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ack_en = 1'b1;
        base = log_q.size();
        seen_we = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen_we |= port_we;
        end
        check_val("flushed_no_write", 64'(log_q.size()), 64'(base));
        check_val("flushed_no_we", seen_we, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_dl_sequencer.md
Name: rom_dl_sequencer

Overview:
Sequences ROM-download bytes from hps_io into the two SDRAM write ports, using toggle req/ack handshakes and one outstanding write at a time. A small FIFO buffers bytes. Address region selects port1 (main/sound CPU ROM) or port2 (sprite ROM, 32-bit merged layout). Bytes outside both regions are dropped here; the core's internal BRAM loader takes them. The block replaces the free-running toggle logic in the top level, adds back-pressure and completion/error reporting, and runs in the clk_mem domain.

Parameters:
SPR_BASE, 25'h10000, first sprite-ROM byte address (port2 region start)
SPR_END, 25'h1C000, first address past sprite ROM (exclusive)
FIFO_DEPTH, 4, byte FIFO entries; power of 2, at least 2
ACK_TIMEOUT, 255, cycles to wait for ack before abandoning a write

Ports:
clk  in  1  memory clock (clk_mem); all logic on rising edge
reset  in  1  asynchronous, active-high
ioctl_download  in  1  download active
ioctl_wr  in  1  byte strobe; may be held multiple cycles, so edge-detect it
ioctl_index  in  8  only index 0 is accepted
ioctl_addr  in  25  byte address
ioctl_dout  in  8  byte data
ioctl_wait  out  1  back-pressure to hps_io
port1_req  out  1  toggle request, port1
port1_ack  in  1  toggle ack, port1
port1_a  out  23  word address
port1_ds  out  2  byte strobes {hi,lo}
port1_d  out  16  write data
port2_req  out  1  toggle request, port2
port2_ack  in  1  toggle ack, port2
port2_a  out  23  word address
port2_ds  out  2  byte strobes
port2_d  out  16  write data
port_we  out  1  write enable for both ports (high in ISSUE/WAIT)
cpu_hold  out  1  holds CPU ROM address muxes while download or drain is active
dl_done  out  1  one-cycle pulse when download ends and FIFO drains
ack_err  out  1  sticky timeout flag; cleared on a new download rising edge or reset

Behaviour:
- Reset values: port1_req=0, port2_req=0, port_we=0, ioctl_wait=0, cpu_hold=0, dl_done=0, ack_err=0, all addr/ds/d=0. FIFO is emptied and the FSM goes to IDLE.
- Capture: on an ioctl_wr rising edge (registered last value) with ioctl_download=1 and ioctl_index=0, push {ioctl_addr, ioctl_dout}. A push while full is lost, but ioctl_wait prevents this. Pulses while download=0 or index≠0 are ignored.
- ioctl_wait = (fifo count >= FIFO_DEPTH-1). It is registered and updates the cycle after a push or pop.
- FSM states:
  - IDLE: when the FIFO is non-empty, pop and go to DECODE.
  - DECODE (1 cycle), address a:
    - a < SPR_BASE is port1: port1_a=a[23:1], port1_ds={a[0],~a[0]}, port1_d={dout,dout}.
    - SPR_BASE <= a < SPR_END is port2: s=a-SPR_BASE, port2_a={s[23:16],s[13:0],s[15]}, port2_ds={s[14],~s[14]}, port2_d={dout,dout}.
    - Any other address is dropped and the FSM returns to IDLE.
  - ISSUE: toggle the selected req, clear the timeout counter, go to WAIT.
  - WAIT: when ack==req for the selected port, go to IDLE. When the counter reaches ACK_TIMEOUT, set ack_err, realign the internal expected ack to the req value, and go to IDLE.
- Latency: from push into an empty FIFO to req toggle is 3 cycles (pop, decode, issue). Throughput is one write per ack round-trip plus 3 cycles.
- Data outputs hold stable from DECODE until the next DECODE. The unused port's outputs keep their previous values.
- cpu_hold = ioctl_download | FIFO non-empty | FSM≠IDLE.
- dl_done fires once, on the cycle cpu_hold falls.
- Download falling mid-transfer: the FIFO still drains and no data is discarded.
- Download rising: clears ack_err only. It does not flush the FIFO.
- Reset mid-transfer: the FIFO is flushed and the req toggles return to 0. The SDRAM side must be reset together with this block.
- The counter is 8 bits wide, enough for ACK_TIMEOUT up to 255, and saturates.

Test Plan:
- Index 0, bytes 0x00000=0xAA then 0x00001=0x55, immediate acks -> port1_a=0, ds=01 then ds=10, d=AAAA then 5555; port1_req toggles twice; port2_req stays 0.
- Byte at 0x14001 (s=0x4001), data 0x3C -> port2_a={8'h00,14'h0001,1'b0}=23'h2, ds=10, d=3C3C.
- Byte at 0x1C000 -> dropped; no req toggles; FSM returns to IDLE within 2 cycles of pop.
- Ack withheld, 4 back-to-back strobes -> ioctl_wait=1 after the 3rd buffered entry. After releasing acks, all 4 writes occur in order and ioctl_wait falls.
- Ack never returned -> ack_err=1 exactly ACK_TIMEOUT cycles after ISSUE, then the next byte proceeds. A new download rising edge clears ack_err.
- Download falls with 2 entries pending -> both are written, then dl_done pulses once and cpu_hold drops the same cycle. A reset asserted mid-WAIT drives req=0 and empties the FIFO asynchronously.
